// File: rtl/ex_stage_mc.sv
// ex_stage_mc: execute stage with Val2, ALU, iterative MUL/MLA, EX/MEM reg.
// Option: EX_MUL_EARLY_TERM_EN ends a multiply once the multiplier is spent.
module ex_stage_mc #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int IMM_W    = 24,
  parameter int MUL_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [3:0]        status_in,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [DATA_W-1:0] acc_in,
  input  logic [IMM_W-1:0]  signed_imm,
  input  logic [11:0]       shift_operand,
  input  logic              is_immediate,
  input  logic [3:0]        exec_cmd,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              wb_en,
  input  logic [3:0]        dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_result,
  output logic [3:0]        status_out,
  output logic [ADDR_W-1:0] branch_address,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_wb_en,
  output logic [3:0]        out_dest,
  output logic              busy
);

  localparam int K  = DATA_W / MUL_BITS;
  localparam int CW = $clog2(K + 1);

  localparam logic [3:0] C_MOV = 4'b0001;
  localparam logic [3:0] C_MVN = 4'b1001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_ADC = 4'b0011;
  localparam logic [3:0] C_SUB = 4'b0100;
  localparam logic [3:0] C_SBC = 4'b0101;
  localparam logic [3:0] C_AND = 4'b0110;
  localparam logic [3:0] C_ORR = 4'b0111;
  localparam logic [3:0] C_EOR = 4'b1000;
  localparam logic [3:0] C_MUL = 4'b1010;
  localparam logic [3:0] C_MLA = 4'b1011;

  typedef enum logic {IDLE, MUL_RUN} state_t;
  state_t state_q, state_d;

  logic [DATA_W-1:0] mcand_q, mplier_q, acc_q, part_q;
  logic [CW-1:0]     cnt_q;
  logic              mla_q;
  logic [1:0]        cv_q;
  logic [ADDR_W-1:0] br_q;
  logic              mr_q, mw_q, wb_q;
  logic [3:0]        dest_q;

  logic              accept, is_mul, is_mem, mul_done;
  logic              known, c_f, v_f, cin;
  logic [4:0]        sh_amt;
  logic [2*DATA_W-1:0] dbl;
  logic [DATA_W-1:0] val2, b_eff, alu_res;
  logic [DATA_W:0]   sum;
  logic [3:0]        alu_st;
  logic [DATA_W-1:0] step_add, part_nx, mplier_nx, mul_res;
  logic [ADDR_W-1:0] imm_ext, br_addr;

  assign is_mem  = mem_read | mem_write;
  assign is_mul  = (exec_cmd == C_MUL) || (exec_cmd == C_MLA);
  assign busy    = (state_q == MUL_RUN);
  assign in_ready = rst && (state_q == IDLE) && !flush &&
                    (!out_valid || out_ready);
  assign accept  = in_valid && in_ready;
  assign imm_ext = ADDR_W'($signed(signed_imm));
  assign br_addr = pc_in + (imm_ext << 2);

  // Val2: memory offset, rotated immediate, or shifted Rm
  always_comb begin
    val2   = '0;
    dbl    = '0;
    sh_amt = shift_operand[11:7];
    if (is_mem) begin
      val2 = DATA_W'(shift_operand);
    end else if (is_immediate) begin
      dbl  = {DATA_W'(shift_operand[7:0]), DATA_W'(shift_operand[7:0])}
             >> {shift_operand[11:8], 1'b0};
      val2 = dbl[DATA_W-1:0];
    end else begin
      unique case (shift_operand[6:5])
        2'b00:   val2 = op2 << sh_amt;
        2'b01:   val2 = op2 >> sh_amt;
        2'b10:   val2 = $signed(op2) >>> sh_amt;
        default: begin
          dbl  = {op2, op2} >> sh_amt;
          val2 = dbl[DATA_W-1:0];
        end
      endcase
    end
  end

  // Single-cycle ALU with NZCV generation
  always_comb begin
    b_eff   = val2;
    cin     = 1'b0;
    alu_res = '0;
    c_f     = status_in[1];
    v_f     = status_in[0];
    known   = 1'b1;
    if (exec_cmd == C_SUB || exec_cmd == C_SBC) b_eff = ~val2;
    if (exec_cmd == C_ADC || exec_cmd == C_SBC) cin = status_in[1];
    if (exec_cmd == C_SUB) cin = 1'b1;
    sum = {1'b0, op1} + {1'b0, b_eff} + {{DATA_W{1'b0}}, cin};
    case (exec_cmd)
      C_MOV: alu_res = val2;
      C_MVN: alu_res = ~val2;
      C_ADD, C_ADC, C_SUB, C_SBC: begin
        alu_res = sum[DATA_W-1:0];
        c_f     = sum[DATA_W];
        v_f     = (op1[DATA_W-1] == b_eff[DATA_W-1]) &&
                  (sum[DATA_W-1] != op1[DATA_W-1]);
      end
      C_AND: alu_res = op1 & val2;
      C_ORR: alu_res = op1 | val2;
      C_EOR: alu_res = op1 ^ val2;
      default: known = 1'b0;
    endcase
    alu_st = known ? {alu_res[DATA_W-1], alu_res == '0, c_f, v_f} : status_in;
  end

  // Multiply step: partial product update and completion detect
  always_comb begin
    step_add  = mcand_q * DATA_W'(mplier_q[MUL_BITS-1:0]);
    part_nx   = part_q + step_add;
    mplier_nx = mplier_q >> MUL_BITS;
    mul_res   = part_nx + (mla_q ? acc_q : '0);
`ifdef EX_MUL_EARLY_TERM_EN
    mul_done  = (state_q == MUL_RUN) &&
                ((cnt_q == CW'(1)) || (mplier_nx == '0));
`else
    mul_done  = (state_q == MUL_RUN) && (cnt_q == CW'(1));
`endif
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (accept && is_mul) state_d = MUL_RUN;
        MUL_RUN: if (mul_done) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Multiplier operands and pass-through captured at accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      part_q   <= '0;
      cnt_q    <= '0;
      mla_q    <= 1'b0;
      cv_q     <= '0;
      br_q     <= '0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      wb_q     <= 1'b0;
      dest_q   <= '0;
    end else if (accept && is_mul) begin
      mcand_q  <= op1;
      mplier_q <= op2;
      acc_q    <= acc_in;
      part_q   <= '0;
      cnt_q    <= CW'(K);
      mla_q    <= (exec_cmd == C_MLA);
      cv_q     <= status_in[1:0];
      br_q     <= br_addr;
      mr_q     <= mem_read;
      mw_q     <= mem_write;
      wb_q     <= wb_en;
      dest_q   <= dest;
    end else if (state_q == MUL_RUN) begin
      mcand_q  <= mcand_q << MUL_BITS;
      mplier_q <= mplier_nx;
      part_q   <= part_nx;
      cnt_q    <= cnt_q - CW'(1);
    end
  end

  // EX/MEM output register with valid/ready hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid      <= 1'b0;
      alu_result     <= '0;
      status_out     <= '0;
      branch_address <= '0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
      out_wb_en      <= 1'b0;
      out_dest       <= '0;
    end else if (flush) begin
      out_valid      <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid      <= 1'b1;
      alu_result     <= alu_res;
      status_out     <= alu_st;
      branch_address <= br_addr;
      out_mem_read   <= mem_read;
      out_mem_write  <= mem_write;
      out_wb_en      <= wb_en;
      out_dest       <= dest;
    end else if (mul_done) begin
      out_valid      <= 1'b1;
      alu_result     <= mul_res;
      status_out     <= {mul_res[DATA_W-1], mul_res == '0, cv_q};
      branch_address <= br_q;
      out_mem_read   <= mr_q;
      out_mem_write  <= mw_q;
      out_wb_en      <= wb_q;
      out_dest       <= dest_q;
    end else if (out_ready) begin
      out_valid      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage_mc.sv
// tb_ex_stage_mc: directed bench with a transaction-level reference model.
// Build with EX_MUL_EARLY_TERM_EN to check early-terminating multiplies.
module tb_ex_stage_mc;

`ifdef EX_MUL_EARLY_TERM_EN
  localparam int EXP_LAT_76 = 3;
  localparam int EXP_LAT_X2 = 2;
`else
  localparam int EXP_LAT_76 = 32;
  localparam int EXP_LAT_X2 = 32;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [31:0] pc_in = 32'h100;
  logic [3:0]  status_in = 4'h0;
  logic [31:0] op1 = 0, op2 = 0, acc_in = 0;
  logic [23:0] signed_imm = 24'hFFFFFE;
  logic [11:0] shift_operand = 0;
  logic        is_immediate = 1'b0;
  logic [3:0]  exec_cmd = 4'h0;
  logic        mem_read = 1'b0, mem_write = 1'b0, wb_en = 1'b1;
  logic [3:0]  dest = 4'd3;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] alu_result;
  logic [3:0]  status_out;
  logic [31:0] branch_address;
  logic        out_mem_read, out_mem_write, out_wb_en;
  logic [3:0]  out_dest;
  logic        busy;

  always #5 clk = ~clk;

  ex_stage_mc dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .pc_in(pc_in), .status_in(status_in), .op1(op1),
    .op2(op2), .acc_in(acc_in), .signed_imm(signed_imm),
    .shift_operand(shift_operand), .is_immediate(is_immediate),
    .exec_cmd(exec_cmd), .mem_read(mem_read), .mem_write(mem_write),
    .wb_en(wb_en), .dest(dest), .out_valid(out_valid),
    .out_ready(out_ready), .alu_result(alu_result),
    .status_out(status_out), .branch_address(branch_address),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_wb_en(out_wb_en), .out_dest(out_dest), .busy(busy)
  );

  int n_tests = 0;
  int n_fails = 0;
  bit run_chk = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ror_m(input logic [31:0] x, input int n);
    logic [31:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = {y[0], y[31:1]};
    return y;
  endfunction

  function automatic logic [31:0] val2_m(input logic [31:0] rm,
      input logic [11:0] so, input bit imm, input bit mem);
    longint s;
    if (mem) return {20'h0, so};
    if (imm) return ror_m({24'h0, so[7:0]}, 2 * int'(so[11:8]));
    case (so[6:5])
      2'd0: return rm << so[11:7];
      2'd1: return rm >> so[11:7];
      2'd2: begin
        s = longint'($signed(rm));
        s = s >>> so[11:7];
        return s[31:0];
      end
      default: return ror_m(rm, int'(so[11:7]));
    endcase
  endfunction

  function automatic logic [35:0] alu_m(input logic [3:0] cmd,
      input logic [31:0] a, input logic [31:0] rm, input logic [11:0] so,
      input bit imm, input bit mem, input logic [3:0] st);
    logic [31:0] b, r;
    logic [63:0] ua, ub, us, bw;
    longint sa, sb, sr;
    bit c, v;
    b  = val2_m(rm, so, imm, mem);
    c  = st[1];
    v  = st[0];
    ua = {32'h0, a};
    ub = {32'h0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 32'h0;
    case (cmd)
      4'h1: r = b;
      4'h9: r = ~b;
      4'h2, 4'h3: begin
        bw = (cmd == 4'h3) ? {63'h0, st[1]} : 64'h0;
        us = ua + ub + bw;
        sr = sa + sb + longint'(bw);
        r  = us[31:0];
        c  = us > 64'hFFFF_FFFF;
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'h4, 4'h5: begin
        bw = (cmd == 4'h5 && !st[1]) ? 64'h1 : 64'h0;
        us = ua - ub - bw;
        sr = sa - sb - longint'(bw);
        r  = us[31:0];
        c  = ua >= ub + bw;
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'h6: r = a & b;
      4'h7: r = a | b;
      4'h8: r = a ^ b;
      default: return {st, 32'h0};
    endcase
    return {r[31], r == 32'h0, c, v, r};
  endfunction

  function automatic int lat_m(input logic [31:0] b);
`ifdef EX_MUL_EARLY_TERM_EN
    int n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return n;
`else
    return 32 + 0 * int'(b[0]);
`endif
  endfunction

  logic [31:0] m_res = 0, p_res = 0, m_br = 0, p_br = 0;
  logic [3:0]  m_st = 0, p_st = 0;
  logic [6:0]  m_ctl = 0, p_ctl = 0;
  int          m_left = 0;
  logic        m_valid = 1'b0;
  logic        m_ready, m_acc, in_mul;
  logic [31:0] cur_br, cur_mul;
  logic [63:0] prod;

  assign in_mul  = (exec_cmd == 4'hA) || (exec_cmd == 4'hB);
  assign m_ready = rst && (m_left == 0) && !flush && (!m_valid || out_ready);
  assign m_acc   = in_valid && m_ready;
  assign cur_br  = pc_in + {{6{signed_imm[23]}}, signed_imm, 2'b00};
  assign prod    = {32'h0, op1} * {32'h0, op2} +
                   ((exec_cmd == 4'hB) ? {32'h0, acc_in} : 64'h0);
  assign cur_mul = prod[31:0];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid <= 1'b0; m_left <= 0;
      m_res <= 0; m_st <= 0; m_br <= 0; m_ctl <= 0;
    end else if (flush) begin
      m_valid <= 1'b0; m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_valid <= 1'b1; m_res <= p_res; m_st <= p_st;
        m_br <= p_br; m_ctl <= p_ctl;
      end
    end else if (m_acc) begin
      if (in_mul) begin
        m_valid <= 1'b0;
        m_left  <= lat_m(op2);
        p_res   <= cur_mul;
        p_st    <= {cur_mul[31], cur_mul == 32'h0, status_in[1:0]};
        p_br    <= cur_br;
        p_ctl   <= {mem_read, mem_write, wb_en, dest};
      end else begin
        m_valid <= 1'b1;
        {m_st, m_res} <= alu_m(exec_cmd, op1, op2, shift_operand,
                               is_immediate, mem_read | mem_write, status_in);
        m_br    <= cur_br;
        m_ctl   <= {mem_read, mem_write, wb_en, dest};
      end
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (run_chk) begin
      chk("in_ready", 32'(in_ready), 32'(m_ready));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'(m_left > 0));
      if (m_valid) begin
        chk("alu_result", alu_result, m_res);
        chk("status_out", 32'(status_out), 32'(m_st));
        chk("branch_address", branch_address, m_br);
        chk("ctl", 32'({out_mem_read, out_mem_write, out_wb_en, out_dest}),
            32'(m_ctl));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic [3:0] cmd, input logic [31:0] a,
                        input logic [31:0] b, input logic [11:0] so,
                        input bit imm);
    in_valid = 1'b1; exec_cmd = cmd; op1 = a; op2 = b;
    shift_operand = so; is_immediate = imm;
  endtask

  task automatic fire(input logic [3:0] cmd, input logic [31:0] a,
                      input logic [31:0] b, input logic [11:0] so,
                      input bit imm);
    set_in(cmd, a, b, so, imm);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] a, b;
    logic [11:0] so;
    bit          imm, mem;
    logic [3:0]  st;
  } vec_t;

  vec_t vecs[$];
  int   lat, cnt;

  initial begin
    vecs.push_back('{4'h3, 32'h7FFFFFFF, 32'h0, 12'h000, 0, 0, 4'b0010});
    vecs.push_back('{4'h5, 32'd10, 32'd3, 12'h000, 0, 0, 4'b0000});
    vecs.push_back('{4'h5, 32'd10, 32'd3, 12'h000, 0, 0, 4'b0010});
    vecs.push_back('{4'h7, 32'h1, 32'h0000_00F0, 12'h200, 0, 0, 4'h0});
    vecs.push_back('{4'h8, 32'hFFFF_0000, 32'h1234_5678, 12'h460, 0, 0, 4'h0});
    vecs.push_back('{4'h2, 32'h0, 32'h8000_0000, 12'h240, 0, 0, 4'h0});
    vecs.push_back('{4'h2, 32'h0, 32'h8000_0003, 12'h0A0, 0, 0, 4'h0});
    vecs.push_back('{4'h6, 32'hFFFF_FFFF, 32'h0, 12'h4AB, 1, 0, 4'h0});
    vecs.push_back('{4'h9, 32'h0, 32'h0F0F_0F0F, 12'h000, 0, 0, 4'h1});
    vecs.push_back('{4'h2, 32'h1000, 32'h0, 12'hABC, 0, 1, 4'h0});
    vecs.push_back('{4'h4, 32'h8000_0000, 32'h1, 12'h000, 0, 0, 4'h0});
    vecs.push_back('{4'h0, 32'h5, 32'h5, 12'h000, 0, 0, 4'b1010});

    #1 rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_alu_result", alu_result, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    run_chk = 1'b1;
    step();

    // ADD 5 + -5 wraps to 0 with carry
    fire(4'h2, 32'd5, 32'hFFFF_FFFB, 12'h000, 0);
    chk("add_result", alu_result, 32'h0);
    chk("add_status", 32'(status_out), 32'b0110);
    chk("add_valid", 32'(out_valid), 32'h1);
    chk("branch_addr", branch_address, 32'h0000_00F8);

    // SUB 3 - 5 borrows
    fire(4'h4, 32'd3, 32'd5, 12'h000, 0);
    chk("sub_result", alu_result, 32'hFFFF_FFFE);
    chk("sub_status", 32'(status_out), 32'b1000);

    // MOV #0xFF ror 4
    fire(4'h1, 32'h0, 32'h0, 12'h2FF, 1);
    chk("mov_imm", alu_result, 32'hF000_000F);

    // unknown command keeps status
    status_in = 4'b1010;
    fire(4'hF, 32'h7, 32'h9, 12'h000, 0);
    chk("unk_result", alu_result, 32'h0);
    chk("unk_status", 32'(status_out), 32'b1010);

    // table of single-cycle vectors, checked by the model
    foreach (vecs[i]) begin
      status_in = vecs[i].st;
      mem_read  = vecs[i].mem;
      dest      = 4'(i);
      pc_in     = 32'h100 + 32'(i * 4);
      signed_imm = 24'(i) - 24'd3;
      fire(vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].so, vecs[i].imm);
    end
    mem_read = 1'b0; dest = 4'd3;
    pc_in = 32'h100; signed_imm = 24'hFFFFFE;
    step();

    // MUL 7*6 with latched C/V
    status_in = 4'b0011;
    fire(4'hA, 32'd7, 32'd6, 12'h000, 0);
    status_in = 4'b0000;
    chk("mul_busy", 32'(busy), 32'h1);
    chk("mul_in_ready", 32'(in_ready), 32'h0);
    wait_valid(lat);
    chk("mul_latency", 32'(lat), 32'(EXP_LAT_76));
    chk("mul_result", alu_result, 32'd42);
    chk("mul_status", 32'(status_out), 32'b0011);
    step();

    // MLA wraps to zero
    acc_in = 32'h1;
    fire(4'hB, 32'h0000_FFFF, 32'h0001_0001, 12'h000, 0);
    wait_valid(lat);
    chk("mla_result", alu_result, 32'h0);
    chk("mla_status", 32'(status_out), 32'b0100);
    step();

    // multiplier of 2: short when early termination is built in
    fire(4'hA, 32'd9, 32'd2, 12'h000, 0);
    wait_valid(lat);
    chk("mulx2_latency", 32'(lat), 32'(EXP_LAT_X2));
    chk("mulx2_result", alu_result, 32'd18);
    step();

    // back-pressure hold then same-edge hand-off
    out_ready = 1'b0;
    fire(4'h2, 32'd1, 32'd2, 12'h000, 0);
    repeat (3) begin
      step();
      chk("bp_hold", alu_result, 32'd3);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
    end
    set_in(4'h2, 32'd10, 32'd20, 12'h000, 0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    chk("bp_next", alu_result, 32'd30);
    step();

    // flush at cycle 10 of a multiply
    fire(4'hA, 32'd3, 32'h8000_0001, 12'h000, 0);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_mul_valid", 32'(out_valid), 32'h0);
    chk("flush_mul_busy", 32'(busy), 32'h0);
    cnt = 0;
    repeat (40) begin
      step();
      if (out_valid) cnt++;
    end
    chk("flush_no_result", 32'(cnt), 32'h0);

    // flush a held result
    out_ready = 1'b0;
    fire(4'h2, 32'd1, 32'd1, 12'h000, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b1;
    chk("flush_out_valid", 32'(out_valid), 32'h0);
    step();

    // asynchronous reset mid-multiply
    fire(4'hA, 32'd5, 32'hF000_0005, 12'h000, 0);
    repeat (5) step();
    #1 rst = 1'b0;
    #1;
    chk("arst_alu", alu_result, 32'h0);
    chk("arst_branch", branch_address, 32'h0);
    chk("arst_status", 32'(status_out), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_in_ready", 32'(in_ready), 32'h0);
    chk("arst_dest", 32'({out_wb_en, out_dest}), 32'h0);
    @(negedge clk);
    #1 rst = 1'b1;
    step();

    // recovery
    fire(4'h2, 32'd100, 32'd23, 12'h000, 0);
    chk("recover", alu_result, 32'd123);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ex_stage_mc.md
Name: ex_stage_mc

Overview:
- Parametrised, multi-cycle-capable execute stage for the ARM-subset pipeline.
- Performs the single-cycle ALU operations with Val2 operand generation and computes the branch target.
- Adds an iterative MUL/MLA unit, a registered EX/MEM output with a valid/ready handshake, and a synchronous flush.
- Sits between the ID/EX register and the MEM stage, and back-pressures ID through in_ready.

Parameters:
- DATA_W, 32, width of operands and results.
- ADDR_W, 32, PC / branch address width.
- IMM_W, 24, branch signed-immediate width (IMM_W + 2 <= ADDR_W).
- MUL_BITS, 1, multiplier bits retired per cycle; must divide DATA_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- flush  in  1  synchronous kill of in-flight and output contents.
- pc_in  in  ADDR_W  PC of the instruction (already +4).
- status_in  in  4  NZCV from the status register.
- op1  in  DATA_W  Rn value.
- op2  in  DATA_W  Rm value; for MUL/MLA, the multiplier Rs.
- acc_in  in  DATA_W  MLA accumulator.
- signed_imm  in  IMM_W  branch offset in words.
- shift_operand  in  12  Val2 shift/immediate field.
- is_immediate  in  1  I bit.
- exec_cmd  in  4  execute command.
- mem_read, mem_write, wb_en  in  1 each  control bits, passed through.
- dest  in  4  destination register, passed through.
- out_valid  out  1  EX/MEM register holds a result.
- out_ready  in  1  MEM consumes the result.
- alu_result  out  DATA_W  registered result.
- status_out  out  4  registered NZCV.
- branch_address  out  ADDR_W  registered branch target.
- out_mem_read, out_mem_write, out_wb_en  out  1 each  registered pass-through bits.
- out_dest  out  4  registered pass-through destination.
- busy  out  1  FSM in MUL_RUN.

Behaviour:
- Reset (rst = 0, asynchronous):
  - All outputs and registers go to 0.
  - FSM goes to IDLE.
  - in_ready deasserts while rst is low.
- in_ready = state == IDLE && !flush && (!out_valid || out_ready).
- Accept occurs on in_valid && in_ready at a rising edge.
- Commands:
  - MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000.
  - New: MUL 1010 (op1 * op2) and MLA 1011 (op1 * op2 + acc_in).
  - Any other code produces result 0 and leaves status_out equal to status_in.
- Val2 is generated by the existing Val2Generator; is_mem_command = mem_read | mem_write.
- Single-cycle ops: results and flags follow the existing ALU and are loaded into the output register at the accept edge, so out_valid is 1 after that edge.
- branch_address = pc_in + (sign-extend(signed_imm) << 2), truncated to ADDR_W. It is computed for every accepted instruction.
- FSM states: IDLE, MUL_RUN.
  - IDLE -> MUL_RUN on accept of MUL/MLA: latch the multiplicand, multiplier and accumulator; clear the partial product; set count K = DATA_W/MUL_BITS.
  - Each MUL_RUN cycle adds (multiplier[MUL_BITS-1:0] * multiplicand) to the partial product, shifts the multiplicand left and the multiplier right by MUL_BITS, and decrements count.
  - On the edge where count reaches 0: load the output register with the low DATA_W bits (+ acc for MLA), set out_valid, return to IDLE.
- Latency: out_valid is 1 after edge K counted from the accept edge (edge 0). With DATA_W=32 and MUL_BITS=1, that is 32 cycles.
- MUL/MLA flags: N = result[DATA_W-1], Z = (result == 0); C and V are taken from status_in latched at accept.
- Output hold:
  - While out_valid && !out_ready, all out_* registers stay stable.
  - A completing multiply cannot occur in this state, because entry to MUL_RUN required the output register to be free or draining.
  - out_valid clears on out_ready unless a new result loads in the same edge.
- Flush:
  - Return to IDLE and clear out_valid and busy at the next edge.
  - Nothing is accepted that cycle.
  - Flush overrides the completion of a multiply in the same cycle.
- Arithmetic wraps modulo 2^DATA_W. The partial product holds only DATA_W bits.

Optional Feature:
- Macro: EX_MUL_EARLY_TERM_EN.
- When defined, MUL_RUN also completes at the end of any cycle in which the remaining shifted multiplier is 0. Minimum MUL_RUN occupancy is 1 cycle, so op2 = 0 gives out_valid after edge 1.
- When undefined, latency is always exactly K.

Test Plan:
- ADD with op1=5, op2=0xFFFFFFFB, is_immediate=0, shift 0 -> after the accept edge: alu_result=0, status_out Z=1, C=1, out_valid=1.
- MUL 7*6, DATA_W=32, MUL_BITS=1, macro off -> busy for 32 cycles, then alu_result=42, N=0, Z=0, in_ready low throughout.
- MLA 0xFFFF*0x10001 + 1 -> alu_result=0xFFFFFFFF+1 wraps to 0, Z=1. With the macro on and op2=2, out_valid follows after edge 2.
- Back-pressure: hold out_ready=0 with a result registered -> outputs stable and in_ready=0; release out_ready -> the next instruction is accepted on the same edge.
- Flush at cycle 10 of a MUL, and flush with out_valid=1 -> out_valid=0 and busy=0 next cycle, no result emitted.
- Branch: pc_in=0x100, signed_imm=0xFFFFFE -> branch_address=0xF8. Drive rst low mid-MUL -> all outputs 0 immediately.
